// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, default limits
// and requester port indices.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK1 = 2'd1,
        YIELD = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_STARVE_LIMIT = 4;
    localparam int unsigned DEF_LOCK_MAX     = 8;

    localparam int unsigned PORT_CORE = 0;
    localparam int unsigned PORT_EXT  = 1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The arbiter takes the slave view; requesters and memory model take the master view.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned WORD_WIDTH = 16
);
    logic                  in_req0;
    logic                  in_we0;
    logic [ADDR_WIDTH-1:0] in_addr0;
    logic [WORD_WIDTH-1:0] in_wdata0;
    logic                  out_gnt0;
    logic                  out_rvalid0;

    logic                  in_req1;
    logic                  in_we1;
    logic                  in_lock1;
    logic [ADDR_WIDTH-1:0] in_addr1;
    logic [WORD_WIDTH-1:0] in_wdata1;
    logic                  out_gnt1;
    logic                  out_rvalid1;

    logic [WORD_WIDTH-1:0] out_rdata;
    logic [ADDR_WIDTH-1:0] out_mem_addr;
    logic [WORD_WIDTH-1:0] out_mem_word;
    logic                  out_mem_write_en;
    logic [WORD_WIDTH-1:0] in_mem_word;
    logic                  out_stall_core;

    modport slave (
        input  in_req0, in_we0, in_addr0, in_wdata0,
        input  in_req1, in_we1, in_lock1, in_addr1, in_wdata1,
        input  in_mem_word,
        output out_gnt0, out_rvalid0, out_gnt1, out_rvalid1, out_rdata,
        output out_mem_addr, out_mem_word, out_mem_write_en, out_stall_core
    );

    modport master (
        output in_req0, in_we0, in_addr0, in_wdata0,
        output in_req1, in_we1, in_lock1, in_addr1, in_wdata1,
        output in_mem_word,
        input  out_gnt0, out_rvalid0, out_gnt1, out_rvalid1, out_rdata,
        input  out_mem_addr, out_mem_word, out_mem_write_en, out_stall_core
    );

endinterface

// File: rtl/arb_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module arb_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != WIDTH'(MAX))) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: core priority, port-1 starvation
// guard and bounded port-1 burst lock. Optional statistics behind DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned WORD_WIDTH   = 16,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int unsigned LOCK_MAX     = DEF_LOCK_MAX,
    parameter int unsigned CNT_WIDTH    = 4
) (
    input  logic          clock,
    input  logic          reset,
    dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   out_stat_gnt0,
    output logic [15:0]   out_stat_gnt1,
    output logic [15:0]   out_stat_stall0,
    output logic [15:0]   out_stat_forced1
`endif
);

    arb_state_e            r_state;
    arb_state_e            w_next_state;
    logic [1:0]            w_gnt;
    logic                  w_forced;
    logic                  w_lock_inc;
    logic                  w_stall;
    logic [CNT_WIDTH-1:0]  w_starve_cnt;
    logic [CNT_WIDTH-1:0]  w_lock_cnt;
    logic                  r_rvalid0;
    logic                  r_rvalid1;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [WORD_WIDTH-1:0] w_mem_word;
    logic                  w_mem_we;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ARB;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_gnt        = 2'b00;
        w_forced     = 1'b0;
        w_lock_inc   = 1'b0;
        unique case (r_state)
            ARB: begin
                w_forced = bus.in_req0 && bus.in_req1 &&
                           (w_starve_cnt == CNT_WIDTH'(STARVE_LIMIT));
                if (bus.in_req0 && !w_forced) begin
                    w_gnt[PORT_CORE] = 1'b1;
                end else if (bus.in_req1) begin
                    w_gnt[PORT_EXT] = 1'b1;
                    if (bus.in_lock1) begin
                        w_next_state = LOCK1;
                        w_lock_inc   = 1'b1;
                    end
                end
            end
            LOCK1: begin
                if (bus.in_req1) begin
                    w_gnt[PORT_EXT] = 1'b1;
                    w_lock_inc      = 1'b1;
                    if (!bus.in_lock1) begin
                        w_next_state = ARB;
                    end else if (w_lock_cnt == CNT_WIDTH'(LOCK_MAX - 1)) begin
                        w_next_state = YIELD;
                    end
                end else begin
                    w_next_state = ARB;
                end
            end
            YIELD: begin
                if (bus.in_req0) begin
                    w_gnt[PORT_CORE] = 1'b1;
                end else if (bus.in_req1) begin
                    w_gnt[PORT_EXT] = 1'b1;
                end
                w_next_state = ARB;
            end
            default: w_next_state = ARB;
        endcase
        // Grants are combinational, so they must be forced off while reset is held.
        if (!reset) begin
            w_gnt      = 2'b00;
            w_forced   = 1'b0;
            w_lock_inc = 1'b0;
        end
    end

    arb_counter #(.WIDTH(CNT_WIDTH), .MAX(STARVE_LIMIT)) u_starve_cnt (
        .clk   (clock),
        .rst_n (reset),
        .i_clr (w_gnt[PORT_EXT] | ~bus.in_req1),
        .i_inc (bus.in_req1 & ~w_gnt[PORT_EXT]),
        .o_cnt (w_starve_cnt)
    );

    arb_counter #(.WIDTH(CNT_WIDTH), .MAX(LOCK_MAX)) u_lock_cnt (
        .clk   (clock),
        .rst_n (reset),
        .i_clr (w_next_state != LOCK1),
        .i_inc (w_lock_inc),
        .o_cnt (w_lock_cnt)
    );

    always_comb begin
        w_mem_addr = '0;
        w_mem_word = '0;
        w_mem_we   = 1'b0;
        if (w_gnt[PORT_CORE]) begin
            w_mem_addr = bus.in_addr0;
            w_mem_word = bus.in_wdata0;
            w_mem_we   = bus.in_we0;
        end else if (w_gnt[PORT_EXT]) begin
            w_mem_addr = bus.in_addr1;
            w_mem_word = bus.in_wdata1;
            w_mem_we   = bus.in_we1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt[PORT_CORE] & ~bus.in_we0;
            r_rvalid1 <= w_gnt[PORT_EXT] & ~bus.in_we1;
        end
    end

    assign w_stall              = bus.in_req0 & ~w_gnt[PORT_CORE];
    assign bus.out_gnt0         = w_gnt[PORT_CORE];
    assign bus.out_gnt1         = w_gnt[PORT_EXT];
    assign bus.out_rvalid0      = r_rvalid0;
    assign bus.out_rvalid1      = r_rvalid1;
    assign bus.out_rdata        = bus.in_mem_word;
    assign bus.out_mem_addr     = w_mem_addr;
    assign bus.out_mem_word     = w_mem_word;
    assign bus.out_mem_write_en = w_mem_we;
    assign bus.out_stall_core   = w_stall;

`ifdef DMEM_ARB_STATS_EN
    arb_counter #(.WIDTH(16), .MAX(16'hFFFF)) u_stat_gnt0 (
        .clk(clock), .rst_n(reset), .i_clr(1'b0), .i_inc(w_gnt[PORT_CORE]), .o_cnt(out_stat_gnt0)
    );
    arb_counter #(.WIDTH(16), .MAX(16'hFFFF)) u_stat_gnt1 (
        .clk(clock), .rst_n(reset), .i_clr(1'b0), .i_inc(w_gnt[PORT_EXT]), .o_cnt(out_stat_gnt1)
    );
    arb_counter #(.WIDTH(16), .MAX(16'hFFFF)) u_stat_stall0 (
        .clk(clock), .rst_n(reset), .i_clr(1'b0), .i_inc(w_stall), .o_cnt(out_stat_stall0)
    );
    arb_counter #(.WIDTH(16), .MAX(16'hFFFF)) u_stat_forced1 (
        .clk(clock), .rst_n(reset), .i_clr(1'b0), .i_inc(w_forced), .o_cnt(out_stat_forced1)
    );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, priority read, starvation, lock burst,
// lock timeout and asynchronous reset during a lock.
module tb_dmem_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_WIDTH(12), .WORD_WIDTH(16)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_gnt0, stat_gnt1, stat_stall0, stat_forced1;
`endif

    dmem_arbiter #(
        .ADDR_WIDTH(12), .WORD_WIDTH(16), .STARVE_LIMIT(4), .LOCK_MAX(8), .CNT_WIDTH(4)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
`ifdef DMEM_ARB_STATS_EN
        ,
        .out_stat_gnt0    (stat_gnt0),
        .out_stat_gnt1    (stat_gnt1),
        .out_stat_stall0  (stat_stall0),
        .out_stat_forced1 (stat_forced1)
`endif
    );

    // Data memory model: registered read, write on grant; preloaded while reset is held.
    logic [15:0] mem [0:4095];
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[12'h010] <= 16'h1234;
            mem[12'h020] <= 16'hBEEF;
        end else if (bus.out_mem_write_en) begin
            mem[bus.out_mem_addr] <= bus.out_mem_word;
        end
        bus.in_mem_word <= mem[bus.out_mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set0(input logic req, input logic we, input logic [11:0] addr,
                        input logic [15:0] wdata);
        bus.in_req0   = req;
        bus.in_we0    = we;
        bus.in_addr0  = addr;
        bus.in_wdata0 = wdata;
    endtask

    task automatic set1(input logic req, input logic we, input logic lock,
                        input logic [11:0] addr, input logic [15:0] wdata);
        bus.in_req1   = req;
        bus.in_we1    = we;
        bus.in_lock1  = lock;
        bus.in_addr1  = addr;
        bus.in_wdata1 = wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp1;
        logic prev0;
        logic prev1;

        // Reset held with both requesters active
        set0(1'b1, 1'b0, 12'h010, 16'h0);
        set1(1'b1, 1'b0, 1'b0, 12'h020, 16'h0);
        bus.in_mem_word = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt0", bus.out_gnt0, 0);
        check("rst_gnt1", bus.out_gnt1, 0);
        check("rst_rvalid0", bus.out_rvalid0, 0);
        check("rst_rvalid1", bus.out_rvalid1, 0);
        check("rst_we", bus.out_mem_write_en, 0);
        check("rst_addr", bus.out_mem_addr, 0);

        // Release: simultaneous reads, core wins
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("pri_gnt0", bus.out_gnt0, 1);
        check("pri_gnt1", bus.out_gnt1, 0);
        check("pri_stall", bus.out_stall_core, 0);
        check("pri_addr", bus.out_mem_addr, 12'h010);
        check("pri_we", bus.out_mem_write_en, 0);
        tick();
        set0(1'b0, 1'b0, 12'h010, 16'h0);
        @(negedge clk);
        check("pri_rvalid0", bus.out_rvalid0, 1);
        check("pri_rdata0", bus.out_rdata, 16'h1234);
        check("alone_gnt1", bus.out_gnt1, 1);
        check("alone_gnt0", bus.out_gnt0, 0);
        check("alone_addr", bus.out_mem_addr, 12'h020);
        tick();
        set1(1'b0, 1'b0, 1'b0, 12'h020, 16'h0);
        @(negedge clk);
        check("alone_rvalid1", bus.out_rvalid1, 1);
        check("alone_rvalid0", bus.out_rvalid0, 0);
        check("alone_rdata", bus.out_rdata, 16'hBEEF);
        check("idle_gnt1", bus.out_gnt1, 0);
        check("idle_addr", bus.out_mem_addr, 0);
        tick();

        // Starvation: both held, pattern 4x gnt0 then 1x forced gnt1
        set0(1'b1, 1'b0, 12'h030, 16'h0);
        set1(1'b1, 1'b0, 1'b0, 12'h040, 16'h0);
        prev0 = 1'b0;
        prev1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp1 = ((i % 5) == 4);
            @(negedge clk);
            check("starve_gnt0", bus.out_gnt0, !exp1);
            check("starve_gnt1", bus.out_gnt1, exp1);
            check("starve_stall", bus.out_stall_core, exp1);
            check("starve_rvalid0", bus.out_rvalid0, prev0);
            check("starve_rvalid1", bus.out_rvalid1, prev1);
            prev0 = !exp1;
            prev1 = exp1;
            tick();
        end

        // Locked write burst of 3 against a held core request
        set1(1'b1, 1'b1, 1'b1, 12'h100, 16'hA000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("lk_wait_gnt0", bus.out_gnt0, 1);
            check("lk_wait_gnt1", bus.out_gnt1, 0);
            tick();
        end
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            check("lk_gnt1", bus.out_gnt1, 1);
            check("lk_gnt0", bus.out_gnt0, 0);
            check("lk_stall", bus.out_stall_core, 1);
            check("lk_we", bus.out_mem_write_en, 1);
            check("lk_addr", bus.out_mem_addr, 12'h100 + 12'(b));
            check("lk_word", bus.out_mem_word, 16'hA000 + 16'(b));
            tick();
            if (b < 2) begin
                set1(1'b1, 1'b1, (b + 1 < 2), 12'h100 + 12'(b + 1), 16'hA000 + 16'(b + 1));
            end else begin
                set1(1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
            end
        end
        @(negedge clk);
        check("lk_release_gnt0", bus.out_gnt0, 1);
        check("lk_release_gnt1", bus.out_gnt1, 0);
        check("lk_mem100", mem[12'h100], 16'hA000);
        check("lk_mem101", mem[12'h101], 16'hA001);
        check("lk_mem102", mem[12'h102], 16'hA002);
        tick();

        // Lock timeout: 4x gnt0, 8x gnt1, YIELD gnt0, ARB gnt0
        set1(1'b1, 1'b0, 1'b1, 12'h200, 16'h0);
        prev0 = 1'b1;
        prev1 = 1'b0;
        for (int i = 0; i < 14; i++) begin
            exp1 = (i >= 4) && (i <= 11);
            @(negedge clk);
            check("to_gnt0", bus.out_gnt0, !exp1);
            check("to_gnt1", bus.out_gnt1, exp1);
            check("to_rvalid0", bus.out_rvalid0, prev0);
            check("to_rvalid1", bus.out_rvalid1, prev1);
            prev0 = !exp1;
            prev1 = exp1;
            tick();
        end

        // Asynchronous reset while locked with a read in flight
        set0(1'b0, 1'b0, 12'h030, 16'h0);
        set1(1'b1, 1'b0, 1'b1, 12'h020, 16'h0);
        @(negedge clk);
        check("ml_enter_gnt1", bus.out_gnt1, 1);
        tick();
        check("ml_lock_gnt1", bus.out_gnt1, 1);
        check("ml_lock_rvalid1", bus.out_rvalid1, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("ml_rst_gnt1", bus.out_gnt1, 0);
        check("ml_rst_rvalid1", bus.out_rvalid1, 0);
        check("ml_rst_addr", bus.out_mem_addr, 0);
        check("ml_rst_we", bus.out_mem_write_en, 0);
        set0(1'b1, 1'b0, 12'h030, 16'h0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("ml_arb_gnt0", bus.out_gnt0, 1);
        check("ml_arb_gnt1", bus.out_gnt1, 0);
        check("ml_drop_rvalid1", bus.out_rvalid1, 0);
        tick();
        @(negedge clk);
        check("ml_post_rvalid0", bus.out_rvalid0, 1);
        check("ml_post_rvalid1", bus.out_rvalid1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port simulation data memory between two requesters:
  - port 0: the core pipeline memory stage;
  - port 1: an external loader/DMA/debug master.
- Sits between the memory stage's DMEM outputs and the data memory instance.
- Per-cycle grant with fixed core priority, port-1 starvation guard and a bounded port-1 burst lock.
- Returns read data one cycle after grant, tagged to the granted port.

Parameters:
ADDR_WIDTH, 12, DMEM address width
WORD_WIDTH, 16, DMEM word width
STARVE_LIMIT, 4, consecutive denied port-1 cycles before port 1 is forced a grant
LOCK_MAX, 8, maximum consecutive locked port-1 grants before forced release
CNT_WIDTH, 4, width of starvation/lock counters (must hold max(STARVE_LIMIT, LOCK_MAX))

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
in_req0  in  1  port-0 request, held until granted
in_we0  in  1  port-0 write enable (0 = read)
in_addr0  in  ADDR_WIDTH  port-0 address
in_wdata0  in  WORD_WIDTH  port-0 write data
out_gnt0  out  1  port-0 granted this cycle (combinational)
out_rvalid0  out  1  port-0 read data valid (registered)
in_req1  in  1  port-1 request
in_we1  in  1  port-1 write enable
in_lock1  in  1  port-1 requests bus lock for burst
in_addr1  in  ADDR_WIDTH  port-1 address
in_wdata1  in  WORD_WIDTH  port-1 write data
out_gnt1  out  1  port-1 granted this cycle (combinational)
out_rvalid1  out  1  port-1 read data valid (registered)
out_rdata  out  WORD_WIDTH  read data, qualified by out_rvalid0/1
out_mem_addr  out  ADDR_WIDTH  memory address
out_mem_word  out  WORD_WIDTH  memory write data
out_mem_write_en  out  1  memory write enable
in_mem_word  in  WORD_WIDTH  memory read data, one cycle after address
out_stall_core  out  1  in_req0 & ~out_gnt0, used to stall the pipeline

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM to ARB, counters 0.
  - out_rvalid0/1 = 0; out_gnt0/1 = 0 while in reset.
  - Memory outputs all 0; out_mem_write_en = 0.
- At most one grant per cycle. Grant drives out_mem_addr/word/write_en from that port the same cycle. No grant: address 0, write_en 0.
- Read latency 1:
  - out_rvalidN = registered (gntN & ~weN).
  - out_rdata = in_mem_word passed through.
  - Write grants produce no rvalid.
- FSM states:
  - ARB:
    - Port 0 wins if in_req0, unless starve_cnt == STARVE_LIMIT with in_req1; then port 1 wins.
    - Port 1 wins if alone.
    - If port 1 is granted with in_lock1=1, go to LOCK1 with lock_cnt = 1.
  - LOCK1:
    - Only port 1 is grantable; port 0 denied.
    - Each port-1 grant increments lock_cnt.
    - Go to ARB when a granted cycle has in_lock1=0, or when in_req1=0.
    - Go to YIELD when lock_cnt reaches LOCK_MAX.
  - YIELD: one cycle, port 0 has absolute priority (port 1 granted only if in_req0=0), then ARB. Lock is not re-entered from YIELD.
- starve_cnt:
  - Increments when in_req1 & ~gnt1.
  - Clears on gnt1 or ~in_req1.
  - Saturates at STARVE_LIMIT.
- Simultaneous req0/req1 with starve_cnt < STARVE_LIMIT: port 0 wins.
- Requesters must hold all request signals stable until granted; the arbiter does not latch requests.
- Reset mid-lock: FSM returns to ARB and the pending rvalid is dropped.

Optional Feature:
DMEM_ARB_STATS_EN
- With the macro:
  - Adds 16-bit saturating counters out_stat_gnt0, out_stat_gnt1, out_stat_stall0, out_stat_forced1 as output ports.
  - Counters reset to 0.
  - out_stat_forced1 counts grants caused by the starvation rule.
- Without the macro: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the FSM state encoding (ARB=2'd0, LOCK1=2'd1, YIELD=2'd2);
  - default STARVE_LIMIT/LOCK_MAX constants;
  - the port-index constants.
- One natural sub-module: arb_counter, a parameterised saturating counter with clear. It is instanced for starve_cnt, lock_cnt and the stats counters.

Test Plan:
- Reset: hold reset=0 with both reqs high -> gnts, rvalids, write_en all 0. Release -> next cycle gnt0=1.
- Priority read:
  - Stimulus: req0 read addr 0x010 and req1 read addr 0x020 in the same cycle; memory preloaded with 0x1234 at 0x010.
  - Response: gnt0=1, gnt1=0, stall_core=0; next cycle rvalid0=1, rdata=0x1234.
- Starvation:
  - Stimulus: req0 and req1 held continuously.
  - Response: gnt0 for 4 cycles, then gnt1 for 1 cycle with stall_core=1, then the pattern repeats.
- Lock: req1+lock1 write burst of 3 to 0x100..0x102 with req0 held -> 3 consecutive gnt1, stall_core=1, memory holds the data; gnt0 on the cycle after lock1 drops.
- Lock timeout:
  - Stimulus: req1+lock1 held for 12 cycles, req0 held.
  - Response: 8 gnt1, then YIELD gives gnt0, then ARB.
- Asynchronous reset: assert reset=0 mid-lock between clock edges -> outputs clear immediately; after release, FSM is in ARB and no rvalid is produced for the in-flight read.
